uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serialises bytes into 8N1-style UART frames (start 0, 8 data LSB-first, stop 1) on o_tx.
//   Upstream stage of the UART receive path: o_tx drives the receiver's serial input.
//   Valid/ready byte input with a one-entry holding register, so frames go out back-to-back.
//   Single clock domain; bit timing from an internal clock-enable divider.
// PARAMETERS
//   CLKS_PER_BIT  1  i_clk cycles per serial bit (>=1); 1 = one bit per clock
//   STOP_BITS     1  stop bits per frame (1 or 2; other values illegal)
// PORTS
//   i_clk    in   1  sole clock, all logic on posedge
//   i_rst    in   1  reset, synchronous, active-high
//   i_data   in   8  byte to send, sampled when i_valid && o_ready
//   i_valid  in   1  i_data valid
//   o_ready  out  1  holding register empty; transfer on posedge with i_valid && o_ready
//   o_tx     out  1  serial line, idle high, registered
//   o_busy   out  1  frame in progress or byte held
// BEHAVIOUR
//   Reset (i_rst high at posedge): o_tx=1, o_ready=0 while i_rst high, o_busy=0, FSM=IDLE.
//     Holding register emptied, divider and bit counter cleared.
//     Mid-frame reset aborts the frame: o_tx=1 from the next edge, held byte dropped.
//     o_ready=1 on the first edge after i_rst deasserts.
//   Handshake:
//     o_ready = !hold_full && !i_rst; no combinational path from i_valid or i_data.
//     i_data is copied into hold on accept; i_valid without o_ready is ignored.
//     Upstream must keep data stable while stalled.
//   FSM states IDLE, START, DATA, STOP:
//     IDLE: o_tx=1. If hold_full, move hold into the shifter, clear hold, go to START.
//       The divider restarts at that edge.
//     START: o_tx=0 for CLKS_PER_BIT clocks, then DATA with bit_idx=0.
//     DATA: o_tx=shift[0] for CLKS_PER_BIT clocks per bit, then shift right and bit_idx++.
//       After bit_idx 7, go to STOP.
//     STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT clocks.
//       At the end, if hold_full, load the shifter and go directly to START (no idle gap).
//       Otherwise go to IDLE.
//   Latency: byte accepted at edge N while IDLE and empty.
//     Start bit appears on o_tx after edge N+1.
//     Frame lasts (9+STOP_BITS)*CLKS_PER_BIT clocks.
//   Simultaneous events: in the cycle hold moves to the shifter, hold is seen empty only from the next edge.
//     o_ready rises one cycle after the load; no same-cycle accept-and-load.
//   Divider: counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT+1).
//     bit_end when count==CLKS_PER_BIT-1; wrap to 0.
//     With CLKS_PER_BIT=1, bit_end is constantly 1.
//   Bit/stop counters saturate nowhere. Values are compared exactly; no wrap beyond the defined range.
//   o_busy = (state!=IDLE) || hold_full; registered.
// STRUCTURE
//   Package uart_pkg: state localparams (IDLE/START/DATA/STOP, 2 bits), UART_DATA_W=8.
//     Also START_LVL=0, STOP_LVL=1; shared with the receiver.
//   Sub-module uart_baud_gen: CLKS_PER_BIT divider with i_clk, i_rst, i_restart -> o_bit_end.
//   Top level: holding register, shifter, FSM, bit/stop counters, output registers.
// TESTING
//   1. Reset: i_rst high 3 clocks mid-frame -> o_tx=1, o_busy=0 next edge.
//      o_ready=1 one edge after release; no residual bits.
//   2. Single byte 0xA5, CLKS_PER_BIT=1 -> o_tx = 0,1,0,1,0,0,1,0,1,1 on consecutive clocks.
//      Then idle high, o_busy falls.
//   3. Back-to-back 0x00 then 0xFF, CLKS_PER_BIT=4.
//      Second accepted while first is shifting; o_ready low until the load.
//      Expected: 36 clocks low, then 4 clocks stop-high, then 4 clocks start-low, 32 clocks data-high, 4 clocks stop-high.
//   4. STOP_BITS=2, CLKS_PER_BIT=3, byte 0x81 -> stop high 6 clocks.
//      Total frame 33 clocks; bit widths checked exactly.
//   5. Stall: i_valid held with 0x3C while hold is full.
//      Exactly one accept per o_ready pulse; no duplicate or lost byte.
//   6. Random 200 bytes with random i_valid gaps.
//      A bit-level sampler decodes o_tx; its scoreboard matches the input order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame levels, data width and transmitter FSM states.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   // Line levels for the framing bits; the receiver uses the same values.
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: pulses o_bit_end on the last clock of every serial bit.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_bit_end
);

   localparam int unsigned   CW   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Count clocks inside the current bit; a restart realigns the count to a frame start.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart) begin
         count <= '0;
      end else if (o_bit_end) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // With one clock per bit the counter stays at zero, so every clock ends a bit.
   assign o_bit_end = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register feeding an 8N1/8N2 serialiser.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [UART_DATA_W-1:0] i_data,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic                   o_tx,
   output logic                   o_busy
);

   localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);

   state_t                 state;
   logic [UART_DATA_W-1:0] hold;
   logic                   hold_full;
   logic [UART_DATA_W-1:0] shift;
   logic [2:0]             bit_idx;
   logic [0:0]             stop_cnt;

   logic bit_end;
   logic accept;
   logic frame_end;
   logic load;
   logic restart;
   logic active_next;
   logic busy_next;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (restart),
      .o_bit_end (bit_end)
   );

   // Ready depends only on the holding register and reset, never on i_valid.
   assign o_ready = !hold_full && !i_rst;

   // Handshake, load and next-busy decisions shared by the registered FSM.
   always_comb begin
      accept      = i_valid && o_ready;
      frame_end   = (state == STOP) && bit_end && (stop_cnt == LAST_STOP);
      load        = hold_full && ((state == IDLE) || frame_end);
      restart     = hold_full && (state == IDLE);
      // busy is registered, so it is built from the values state and hold take at this edge
      active_next = load || ((state != IDLE) && !frame_end);
      busy_next   = active_next || accept || (hold_full && !load);
   end

   // Frame FSM with holding register, shifter, counters and registered line/busy outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         shift     <= '0;
         bit_idx   <= '0;
         stop_cnt  <= '0;
         o_tx      <= STOP_LVL;
         o_busy    <= 1'b0;
      end else begin
         o_busy <= busy_next;

         if (accept) begin
            hold      <= i_data;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         case (state)
            IDLE: begin
               o_tx <= STOP_LVL;
               if (load) begin
                  shift <= hold;
                  state <= START;
                  o_tx  <= START_LVL;
               end
            end

            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  o_tx    <= shift[0];
               end
            end

            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     state    <= STOP;
                     stop_cnt <= '0;
                     o_tx     <= STOP_LVL;
                  end else begin
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                     o_tx    <= shift[1];
                  end
               end
            end

            STOP: begin
               if (frame_end) begin
                  if (load) begin
                     shift <= hold;
                     state <= START;
                     o_tx  <= START_LVL;
                  end else begin
                     state <= IDLE;
                     o_tx  <= STOP_LVL;
                  end
               end else if (bit_end) begin
                  stop_cnt <= stop_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               o_tx  <= STOP_LVL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three parameterisations, waveform vectors and a byte scoreboard.
module tb_uart_transmitter;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       valid;
   logic [2:0]       ready;
   logic [2:0]       tx;
   logic [2:0]       busy;
   logic [2:0][7:0]  data;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] byte_q[$];
   string      wave_q[$];

   typedef struct {
      int         d;
      logic [7:0] b;
      string      pat;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_data(data[0]), .i_valid(valid[0]),
      .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0])
   );

   uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_data(data[1]), .i_valid(valid[1]),
      .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1])
   );

   uart_transmitter #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_data(data[2]), .i_valid(valid[2]),
      .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2])
   );

   function automatic int unsigned cpb_of(input int d);
      case (d)
         0:       return 1;
         1:       return 4;
         default: return 3;
      endcase
   endfunction

   function automatic int unsigned sb_of(input int d);
      return (d == 2) ? 2 : 1;
   endfunction

   function automatic string rep(input string c, input int unsigned n);
      string s = "";
      for (int unsigned i = 0; i < n; i++) s = {s, c};
      return s;
   endfunction

   function automatic string expand(input string pat, input int unsigned cpb);
      string s = "";
      for (int i = 0; i < pat.len(); i++) s = {s, rep(pat.substr(i, i), cpb)};
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_s(input string name, input string act, input string exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %s, expected %s", name, act, exp);
      end
   endtask

   task automatic add_vec(input int d, input logic [7:0] b, input string pat);
      vec_t v;
      v.d   = d;
      v.b   = b;
      v.pat = pat;
      vecs.push_back(v);
   endtask

   // Starts and ends on a negedge; ok reports whether ready was seen within the budget.
   task automatic wait_ready(input int d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (ready[d] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("wait_ready", 32'(ready[d]), 32'd1);
   endtask

   task automatic run_vec(input int d, input logic [7:0] b, input string pat, input string name);
      bit    ok;
      string e;
      string act;
      e = expand(pat, cpb_of(d));
      wait_ready(d, ok);
      wave_q.push_back(e);
      data[d]  = b;
      valid[d] = 1'b1;
      @(posedge clk);
      #1 valid[d] = 1'b0;
      @(negedge clk);
      check({name, "_latency_tx"}, 32'(tx[d]), 32'd1);
      check({name, "_busy"}, 32'(busy[d]), 32'd1);
      act = "";
      for (int k = 0; k < e.len(); k++) begin
         @(negedge clk);
         if (tx[d] === 1'b1) act = {act, "1"};
         else                act = {act, "0"};
      end
      check_s({name, "_wave"}, act, wave_q.pop_front());
      @(negedge clk);
      check({name, "_idle_tx"}, 32'(tx[d]), 32'd1);
      check({name, "_idle_busy"}, 32'(busy[d]), 32'd0);
   endtask

   task automatic back_to_back();
      bit    ok;
      string act_tx;
      string act_rdy;
      string exp_rdy;
      exp_rdy = {"1", rep("0", 39), rep("1", 40)};
      wave_q.push_back({rep("0", 36), rep("1", 4), rep("0", 4), rep("1", 32), rep("1", 4)});
      wait_ready(1, ok);
      data[1]  = 8'h00;
      valid[1] = 1'b1;
      @(posedge clk);
      #1 data[1] = 8'hFF;
      @(posedge clk);
      act_tx  = "";
      act_rdy = "";
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         act_tx  = {act_tx,  (tx[1]    === 1'b1) ? "1" : "0"};
         act_rdy = {act_rdy, (ready[1] === 1'b1) ? "1" : "0"};
         if (k == 1) valid[1] = 1'b0;
      end
      check_s("b2b_wave", act_tx, wave_q.pop_front());
      check_s("b2b_ready", act_rdy, exp_rdy);
      @(negedge clk);
      check("b2b_idle_busy", 32'(busy[1]), 32'd0);
   endtask

   // Bit-level frame decoder: every sample of a bit must agree, framing levels exact.
   task automatic decode(input int d, input int n, input string name);
      int unsigned cpb;
      int unsigned sb;
      int          wait_c;
      bit          bad;
      logic [7:0]  got;
      cpb = cpb_of(d);
      sb  = sb_of(d);
      for (int f = 0; f < n; f++) begin
         wait_c = 0;
         bad    = 1'b0;
         got    = '0;
         while (tx[d] !== 1'b0 && wait_c < 400) begin
            @(negedge clk);
            wait_c++;
         end
         if (tx[d] !== 1'b0) begin
            check({name, "_start_seen"}, 32'(tx[d]), 32'd0);
            break;
         end
         for (int unsigned i = 1; i < cpb; i++) begin
            @(negedge clk);
            if (tx[d] !== 1'b0) bad = 1'b1;
         end
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            got[b] = tx[d];
            for (int unsigned i = 1; i < cpb; i++) begin
               @(negedge clk);
               if (tx[d] !== got[b]) bad = 1'b1;
            end
         end
         for (int unsigned i = 0; i < cpb * sb; i++) begin
            @(negedge clk);
            if (tx[d] !== 1'b1) bad = 1'b1;
         end
         check({name, "_framing"}, 32'(bad), 32'd0);
         check({name, "_queued"}, 32'(byte_q.size() != 0), 32'd1);
         if (byte_q.size() != 0) check({name, "_byte"}, 32'(got), 32'(byte_q.pop_front()));
      end
   endtask

   task automatic drive_random(input int d, input int n);
      bit         ok;
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         b        = 8'($urandom);
         data[d]  = b;
         valid[d] = 1'b1;
         wait_ready(d, ok);
         if (ok) byte_q.push_back(b);
         @(posedge clk);
         #1 valid[d] = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic stall_drive(input int d, input int n);
      int   acc;
      int   cyc;
      logic prev;
      acc      = 0;
      cyc      = 0;
      prev     = 1'b0;
      data[d]  = 8'h3C;
      valid[d] = 1'b1;
      while (cyc < 1000) begin
         if (ready[d] === 1'b1) begin
            check("stall_single_pulse", 32'(prev), 32'd0);
            acc++;
            byte_q.push_back(8'h3C);
         end
         prev = ready[d];
         if (acc == n) begin
            @(posedge clk);
            #1 valid[d] = 1'b0;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("stall_accepts", 32'(acc), 32'(n));
      @(negedge clk);
   endtask

   task automatic reset_mid_frame();
      bit ok;
      int bad;
      wait_ready(1, ok);
      data[1]  = 8'h55;
      valid[1] = 1'b1;
      @(posedge clk);
      #1 data[1] = 8'hAA;
      @(negedge clk);
      wait_ready(1, ok);
      @(posedge clk);
      #1 valid[1] = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_pre_busy", 32'(busy[1]), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(tx[1]), 32'd1);
      check("rst_busy", 32'(busy[1]), 32'd0);
      check("rst_ready_low", 32'(ready[1]), 32'd0);
      repeat (2) @(negedge clk);
      check("rst_ready_held_low", 32'(ready[1]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready_after", 32'(ready[1]), 32'd1);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx[1] !== 1'b1 || busy[1] !== 1'b0) bad++;
      end
      check("rst_no_residual", 32'(bad), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      add_vec(0, 8'hA5, "0101001011");
      add_vec(0, 8'h00, "0000000001");
      add_vec(0, 8'hFF, "0111111111");
      add_vec(2, 8'h81, "01000000111");
      add_vec(1, 8'h3C, "0001111001");
      add_vec(2, 8'h5A, "00101101011");

      rst   = 1'b1;
      valid = '0;
      data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_tx%0d", d), 32'(tx[d]), 32'd1);
         check($sformatf("reset_busy%0d", d), 32'(busy[d]), 32'd0);
         check($sformatf("reset_ready%0d", d), 32'(ready[d]), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) check($sformatf("release_ready%0d", d), 32'(ready[d]), 32'd1);

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i].d, vecs[i].b, vecs[i].pat, $sformatf("vec%0d", i));

      back_to_back();

      fork
         stall_drive(2, 4);
         decode(2, 4, "stall");
      join
      check("stall_queue_empty", 32'(byte_q.size()), 32'd0);

      fork
         drive_random(1, 200);
         decode(1, 200, "rand");
      join
      check("rand_queue_empty", 32'(byte_q.size()), 32'd0);

      reset_mid_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
